// File: rtl/tcbnn_axis_pkg.sv
// Shared definitions for the AXI-Stream pixel unpacker.
//   DEF_PIX_WIDTH / DEF_LANES / DEF_FRAME_PIXELS : default parameter values
//   state_t : unpacker FSM state
//     ST_EMPTY | no input word held, ready for a new beat
//     ST_DRAIN | word held, current lane is being presented downstream
package tcbnn_axis_pkg;

  localparam int DEF_PIX_WIDTH    = 8;
  localparam int DEF_LANES        = 4;
  localparam int DEF_FRAME_PIXELS = 784;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/axis_pixel_unpack.sv
// axis_pixel_unpack: splits LANES-wide packed pixel beats into a stream of
// single pixels, with a per-frame pixel index and a sticky frame-length check.
//
// Ports
//   axi_clk        in   sole clock, rising edge
//   axi_reset      in   synchronous active-high reset
//   s_axis_valid   in   input beat valid
//   s_axis_data    in   LANES*PIX_WIDTH packed pixels, lane 0 in the LSBs
//   s_axis_last    in   final beat of an input frame
//   s_axis_keep    in   (AXIS_UNPACK_KEEP_EN only) per-lane enable
//   s_axis_ready   out  beat accepted when valid & ready
//   m_axis_valid   out  output pixel valid
//   m_axis_data    out  one pixel
//   m_axis_last    out  pixel is index FRAME_PIXELS-1 of its frame
//   m_axis_ready   in   downstream accepts pixel
//   frame_err      out  sticky: a word's last flag disagreed with frame position
//   pix_count      out  index of the current output pixel within its frame
//
// Build option: define AXIS_UNPACK_KEEP_EN to add s_axis_keep. Lanes with
// keep=0 are skipped without costing a cycle; an all-zero keep word is
// accepted and dropped (its last flag is ignored).
module axis_pixel_unpack
  import tcbnn_axis_pkg::*;
#(
  parameter int PIX_WIDTH    = DEF_PIX_WIDTH,
  parameter int LANES        = DEF_LANES,
  parameter int FRAME_PIXELS = DEF_FRAME_PIXELS
) (
  input  logic                            axi_clk,
  input  logic                            axi_reset,
  input  logic                            s_axis_valid,
  input  logic [LANES*PIX_WIDTH-1:0]      s_axis_data,
  input  logic                            s_axis_last,
`ifdef AXIS_UNPACK_KEEP_EN
  input  logic [LANES-1:0]                s_axis_keep,
`endif
  output logic                            s_axis_ready,
  output logic                            m_axis_valid,
  output logic [PIX_WIDTH-1:0]            m_axis_data,
  output logic                            m_axis_last,
  input  logic                            m_axis_ready,
  output logic                            frame_err,
  output logic [$clog2(FRAME_PIXELS)-1:0] pix_count
);

  localparam int CW = $clog2(FRAME_PIXELS);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  state_t                     state;
  logic [LANES*PIX_WIDTH-1:0] word;
  logic                       word_last;
  logic [LW-1:0]              lane;
  logic [CW-1:0]              pix;
  logic                       err;

  logic                       final_lane;
  logic [LW-1:0]              lane_next;
  logic [LW-1:0]              lane_first;
  logic                       first_any;
  logic                       frame_end;
  logic                       m_hs;
  logic                       s_hs;
  logic [PIX_WIDTH-1:0]       lane_pix;

`ifdef AXIS_UNPACK_KEEP_EN
  logic [LANES-1:0]           keep_h;

  // Next lane is the lowest kept lane above the current one; none means
  // the current lane is the word's last emitted pixel.
  always_comb begin
    final_lane = 1'b1;
    lane_next  = lane;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (keep_h[i] && (LW'(i) > lane)) begin
        final_lane = 1'b0;
        lane_next  = LW'(i);
      end
    end
  end

  always_comb begin
    first_any  = 1'b0;
    lane_first = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (s_axis_keep[i]) begin
        first_any  = 1'b1;
        lane_first = LW'(i);
      end
    end
  end
`else
  assign final_lane = (lane == LW'(LANES - 1));
  assign lane_next  = lane + 1'b1;
  assign lane_first = '0;
  assign first_any  = 1'b1;
`endif

  always_comb begin
    lane_pix = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane == LW'(i)) lane_pix = word[i*PIX_WIDTH +: PIX_WIDTH];
    end
  end

  // Outputs are gated by reset so the interface is quiet from the first
  // cycle reset is seen, not only after the registers have cleared.
  assign frame_end    = (pix == CW'(FRAME_PIXELS - 1));
  assign m_axis_valid = !axi_reset && (state == ST_DRAIN);
  assign m_axis_data  = m_axis_valid ? lane_pix : '0;
  assign m_axis_last  = m_axis_valid && frame_end;
  assign m_hs         = m_axis_valid && m_axis_ready;
  // Accepting on the final lane's handshake is what removes the bubble.
  assign s_axis_ready = !axi_reset &&
                        ((state == ST_EMPTY) ||
                         ((state == ST_DRAIN) && final_lane && m_axis_ready));
  assign s_hs         = s_axis_valid && s_axis_ready;
  assign frame_err    = err;
  assign pix_count    = pix;

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state     <= ST_EMPTY;
      word      <= '0;
      word_last <= 1'b0;
      lane      <= '0;
      pix       <= '0;
      err       <= 1'b0;
`ifdef AXIS_UNPACK_KEEP_EN
      keep_h    <= '0;
`endif
    end else begin
      if (m_hs) begin
        pix <= frame_end ? '0 : pix + 1'b1;
        if (final_lane && (word_last ^ frame_end)) err <= 1'b1;
        if (final_lane) state <= ST_EMPTY;
        else            lane  <= lane_next;
      end
      // A new beat overrides the drain-to-empty move above.
      if (s_hs) begin
        if (first_any) begin
          word      <= s_axis_data;
          word_last <= s_axis_last;
          lane      <= lane_first;
          state     <= ST_DRAIN;
`ifdef AXIS_UNPACK_KEEP_EN
          keep_h    <= s_axis_keep;
`endif
        end else begin
          state <= ST_EMPTY;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_pixel_unpack.sv
// Testbench for axis_pixel_unpack (FRAME_PIXELS=8). A queue-based model of
// the pixel stream is checked against the DUT on every falling edge;
// directed scenarios add literal expectations.
module tb_axis_pixel_unpack;

  localparam int PW = 8;
  localparam int LN = 4;
  localparam int FP = 8;
  localparam int CW = $clog2(FP);

  logic             axi_clk = 1'b0;
  logic             axi_reset = 1'b1;
  logic             s_axis_valid = 1'b0;
  logic [LN*PW-1:0] s_axis_data = '0;
  logic             s_axis_last = 1'b0;
  logic             m_axis_ready = 1'b0;
  logic             s_axis_ready;
  logic             m_axis_valid;
  logic [PW-1:0]    m_axis_data;
  logic             m_axis_last;
  logic             frame_err;
  logic [CW-1:0]    pix_count;
`ifdef AXIS_UNPACK_KEEP_EN
  logic [LN-1:0]    s_axis_keep = '1;
`endif

  always #5 axi_clk = ~axi_clk;

  axis_pixel_unpack #(.PIX_WIDTH(PW), .LANES(LN), .FRAME_PIXELS(FP)) dut (
    .axi_clk      (axi_clk),
    .axi_reset    (axi_reset),
    .s_axis_valid (s_axis_valid),
    .s_axis_data  (s_axis_data),
    .s_axis_last  (s_axis_last),
`ifdef AXIS_UNPACK_KEEP_EN
    .s_axis_keep  (s_axis_keep),
`endif
    .s_axis_ready (s_axis_ready),
    .m_axis_valid (m_axis_valid),
    .m_axis_data  (m_axis_data),
    .m_axis_last  (m_axis_last),
    .m_axis_ready (m_axis_ready),
    .frame_err    (frame_err),
    .pix_count    (pix_count)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  bit rst_q = 1'b0;

  typedef struct {
    logic [PW-1:0] d;
    logic          wl;
  } exp_t;

  exp_t q[$];
  int   mpix = 0;
  bit   merr = 1'b0;

  logic [PW-1:0] log_d[$];
  int            log_c[$];
  int            log_p[$];
  bit            log_l[$];
  bit            log_r[$];
  int            acc_c[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge axi_clk) begin
    cyc   <= cyc + 1;
    rst_q <= axi_reset;
  end

  // Model: the held word is a queue of the pixels still to be emitted.
  always @(negedge axi_clk) begin
    if (axi_reset) begin
      if (rst_q) begin
        chk("rst_m_valid", {31'b0, m_axis_valid}, 0);
        chk("rst_s_ready", {31'b0, s_axis_ready}, 0);
        chk("rst_m_data", {24'b0, m_axis_data}, 0);
        chk("rst_m_last", {31'b0, m_axis_last}, 0);
        chk("rst_frame_err", {31'b0, frame_err}, 0);
        chk("rst_pix_count", {29'b0, pix_count}, 0);
      end
      q.delete();
      mpix = 0;
      merr = 1'b0;
    end else begin
      chk("m_valid", {31'b0, m_axis_valid}, {31'b0, q.size() != 0});
      chk("s_ready", {31'b0, s_axis_ready},
          {31'b0, (q.size() == 0) || (q.size() == 1 && m_axis_ready)});
      chk("frame_err", {31'b0, frame_err}, {31'b0, merr});
      if (q.size() != 0) begin
        chk("m_data", {24'b0, m_axis_data}, {24'b0, q[0].d});
        chk("pix_count", {29'b0, pix_count}, mpix);
        chk("m_last", {31'b0, m_axis_last}, {31'b0, mpix == FP - 1});
        if (m_axis_ready && m_axis_valid) begin
          if (q.size() == 1 && (q[0].wl != (mpix == FP - 1))) merr = 1'b1;
          log_d.push_back(m_axis_data);
          log_c.push_back(cyc);
          log_p.push_back(mpix);
          log_l.push_back(m_axis_last);
          log_r.push_back(s_axis_ready);
          void'(q.pop_front());
          mpix = (mpix + 1) % FP;
        end
      end
      if (s_axis_valid && s_axis_ready) begin
        acc_c.push_back(cyc);
        for (int i = 0; i < LN; i++) begin
          exp_t e;
          e.d  = s_axis_data[i*PW +: PW];
          e.wl = s_axis_last;
`ifdef AXIS_UNPACK_KEEP_EN
          if (s_axis_keep[i]) q.push_back(e);
`else
          q.push_back(e);
`endif
        end
      end
    end
  end

  task automatic clear_logs();
    log_d.delete(); log_c.delete(); log_p.delete();
    log_l.delete(); log_r.delete(); acc_c.delete();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge axi_clk);
    #1;
  endtask

  task automatic do_reset();
    axi_reset = 1'b1;
    wait_cyc(3);
    axi_reset = 1'b0;
  endtask

  task automatic send(input logic [LN*PW-1:0] d, input logic l);
    int n;
    n = 0;
    s_axis_data  = d;
    s_axis_last  = l;
    s_axis_valid = 1'b1;
    forever begin
      @(negedge axi_clk);
      if (s_axis_ready) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge axi_clk);
    #1;
  endtask

  task automatic idle();
    s_axis_valid = 1'b0;
    s_axis_last  = 1'b0;
  endtask

  initial begin
    // Single word, free-running downstream.
    do_reset();
    m_axis_ready = 1'b1;
    clear_logs();
    send(32'h04030201, 1'b0);
    idle();
    wait_cyc(6);
    chk("w1_count", log_d.size(), 4);
    if (log_d.size() == 4 && acc_c.size() == 1) begin
      chk("w1_px0", {24'b0, log_d[0]}, 32'h01);
      chk("w1_px1", {24'b0, log_d[1]}, 32'h02);
      chk("w1_px2", {24'b0, log_d[2]}, 32'h03);
      chk("w1_px3", {24'b0, log_d[3]}, 32'h04);
      chk("w1_latency", log_c[0], acc_c[0] + 1);
      chk("w1_consecutive", log_c[3], log_c[0] + 3);
      chk("w1_sready_px0", {31'b0, log_r[0]}, 0);
      chk("w1_sready_px3", {31'b0, log_r[3]}, 1);
    end

    // Full 8-pixel frame from two back-to-back words.
    do_reset();
    clear_logs();
    send(32'h14131211, 1'b0);
    send(32'h18171615, 1'b1);
    idle();
    wait_cyc(10);
    chk("fr_count", log_d.size(), 8);
    if (log_d.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("fr_px", {24'b0, log_d[i]}, 32'h11 + i);
        chk("fr_last", {31'b0, log_l[i]}, {31'b0, i == 7});
      end
      chk("fr_no_bubble", log_c[7], log_c[0] + 7);
    end
    chk("fr_err_clear", {31'b0, frame_err}, 0);

    // Downstream stall 1,0,0,1 mid-word.
    do_reset();
    clear_logs();
    m_axis_ready = 1'b0;
    send(32'h24232221, 1'b0);
    idle();
    m_axis_ready = 1'b1;
    wait_cyc(1);
    m_axis_ready = 1'b0;
    wait_cyc(2);
    m_axis_ready = 1'b1;
    wait_cyc(6);
    chk("st_count", log_d.size(), 4);
    if (log_d.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("st_px", {24'b0, log_d[i]}, 32'h21 + i);
      chk("st_gap", log_c[1], log_c[0] + 3);
    end

    // Early last: frame_err after pixel 3 and sticky.
    do_reset();
    clear_logs();
    send(32'h34333231, 1'b1);
    idle();
    wait_cyc(6);
    chk("fe_set", {31'b0, frame_err}, 1);
    send(32'h38373635, 1'b1);
    idle();
    wait_cyc(6);
    chk("fe_sticky", {31'b0, frame_err}, 1);
    do_reset();
    chk("fe_cleared", {31'b0, frame_err}, 0);

    // Reset after pixel 2 of a word.
    clear_logs();
    send(32'h44434241, 1'b0);
    idle();
    wait_cyc(2);
    axi_reset = 1'b1;
    @(negedge axi_clk);
    chk("mr_m_valid", {31'b0, m_axis_valid}, 0);
    chk("mr_s_ready", {31'b0, s_axis_ready}, 0);
    chk("mr_px_before", log_d.size(), 2);
    @(posedge axi_clk);
    #1;
    axi_reset = 1'b0;
    clear_logs();
    send(32'h54535251, 1'b0);
    idle();
    wait_cyc(6);
    chk("mr_count", log_d.size(), 4);
    if (log_d.size() == 4) begin
      chk("mr_px0", {24'b0, log_d[0]}, 32'h51);
      chk("mr_pix0", log_p[0], 0);
      chk("mr_px3", {24'b0, log_d[3]}, 32'h54);
    end

`ifdef AXIS_UNPACK_KEEP_EN
    // Sparse keep, then an all-zero keep word with last set.
    do_reset();
    clear_logs();
    s_axis_keep = 4'b1010;
    send(32'h04030201, 1'b0);
    s_axis_keep = 4'b0000;
    send(32'h99999999, 1'b1);
    s_axis_keep = 4'b1111;
    idle();
    wait_cyc(6);
    chk("kp_count", log_d.size(), 2);
    if (log_d.size() == 2) begin
      chk("kp_px0", {24'b0, log_d[0]}, 32'h02);
      chk("kp_px1", {24'b0, log_d[1]}, 32'h04);
      chk("kp_no_gap", log_c[1], log_c[0] + 1);
    end
    chk("kp_err", {31'b0, frame_err}, 0);
    chk("kp_accepts", acc_c.size(), 2);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/axis_pixel_unpack.md
AXIS_PIXEL_UNPACK -- requirements
Module: axis_pixel_unpack

Interface
REQ-001 SHALL take parameter PIX_WIDTH, default 8: bits per pixel.
REQ-002 SHALL take parameter LANES, default 4: pixels per input beat; s_axis_data width = LANES*PIX_WIDTH.
REQ-003 SHALL take parameter FRAME_PIXELS, default 784: pixels per image frame.
REQ-004 SHALL have port axi_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port axi_reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port s_axis_valid  in  1  input beat valid.
REQ-007 SHALL have port s_axis_data  in  LANES*PIX_WIDTH  packed pixels; lane 0 in bits [PIX_WIDTH-1:0].
REQ-008 SHALL have port s_axis_last  in  1  final beat of an input frame.
REQ-009 SHALL have port s_axis_ready  out  1  input beat accepted when valid&ready.
REQ-010 SHALL have port m_axis_valid  out  1  output pixel valid.
REQ-011 SHALL have port m_axis_data  out  PIX_WIDTH  one pixel.
REQ-012 SHALL have port m_axis_last  out  1  pixel is frame pixel FRAME_PIXELS-1.
REQ-013 SHALL have port m_axis_ready  in  1  downstream accepts pixel.
REQ-014 SHALL have port frame_err  out  1  sticky frame-length mismatch flag.
REQ-015 SHALL have port pix_count  out  $clog2(FRAME_PIXELS)  index of the current m_axis pixel within its frame.

Function
REQ-016 SHALL implement states EMPTY (no word held) and DRAIN (word held, lane index valid).
REQ-017 EMPTY: s_axis_ready=1; on s_axis_valid, capture data and last, lane=0, go to DRAIN.
REQ-018 DRAIN: m_axis_valid=1, m_axis_data=held lane; on m_axis_ready, lane+1.
REQ-019 On the final lane, when m_axis_ready=1, s_axis_ready SHALL be 1; if s_axis_valid=1, capture the new word and stay in DRAIN (no bubble), else go to EMPTY.
REQ-020 Sustained throughput SHALL be one pixel per cycle; first pixel latency SHALL be 1 cycle after acceptance.
REQ-021 m_axis_data/m_axis_last SHALL remain stable while m_axis_valid=1 and m_axis_ready=0.
REQ-022 pix_count SHALL increment on each m_axis handshake and wrap from FRAME_PIXELS-1 to 0, including mid-word.
REQ-023 frame_err SHALL be set when a word's final emitted lane handshakes and (held s_axis_last XOR m_axis_last) = 1; cleared only by reset.
REQ-024 s_axis_ready SHALL be 0 in every other cycle.

Reset
REQ-025 While axi_reset=1, the block SHALL hold state=EMPTY, lane=0, pix_count=0, frame_err=0, m_axis_valid=0, m_axis_last=0, m_axis_data=0, s_axis_ready=0.
REQ-026 Reset mid-frame SHALL discard the held word; the first pixel after reset is pix_count=0.

Configuration
REQ-027 With AXIS_UNPACK_KEEP_EN defined, the block SHALL add input s_axis_keep[LANES-1:0] and skip lanes with keep=0 in zero cycles; an all-zero keep word SHALL be accepted and dropped, and its s_axis_last ignored.
REQ-028 Without AXIS_UNPACK_KEEP_EN, the port SHALL be absent and all lanes SHALL be emitted.

Structure
REQ-029 Package tcbnn_axis_pkg SHALL hold the state enum and default PIX_WIDTH/LANES/FRAME_PIXELS constants.
REQ-030 The block SHALL be a single module with no sub-module; lane selection and counters SHALL be inline.

Verification
REQ-031 Reset, then one word 0x04030201, m_axis_ready=1 -> pixels 01,02,03,04 on 4 consecutive cycles, s_axis_ready=1 on cycle 4.
REQ-032 Continuous valid, FRAME_PIXELS=8, two words, second with last -> 8 pixels, no bubble, m_axis_last only on pixel 7, frame_err=0.
REQ-033 m_axis_ready toggled 1,0,0,1 during a word -> data held constant while stalled, no pixel lost or duplicated.
REQ-034 FRAME_PIXELS=8, s_axis_last on the first word -> frame_err=1 after pixel 3 and remains 1 until reset.
REQ-035 axi_reset asserted after pixel 2 of a word -> next cycle m_axis_valid=0, s_axis_ready=0; after release, new word starts at pix_count=0.
REQ-036 KEEP_EN build, keep=4'b1010 on 0x04030201 -> pixels 02,04 only; keep=0 word -> no output.
